button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions a raw, bouncing, active-low push-button into clean, clock-synchronous event signals. The block sits directly upstream of the event counter and seven-segment stage. Its `press_pulse` output provides exactly one single-cycle count enable per confirmed press, so downstream logic needs no edge-tracking of its own. It synchronises the asynchronous pin, filters bounce with a stability counter and reports press/release edges plus a debounced level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised cycles required to accept a transition (10 ms at 50 MHz). Legal range is ≥ 2.
- `REPEAT_DELAY`, default 25000000: hold cycles before the first auto-repeat pulse. Used only with the macro.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent auto-repeat pulses. Used only with the macro.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `btn_n`, in, 1: raw push-button pin, active-low, asynchronous to `clk`.
- `btn_level`, out, 1: debounced level; 1 = pressed.
- `press_pulse`, out, 1: one-cycle pulse per accepted press (and per auto-repeat).
- `release_pulse`, out, 1: one-cycle pulse per accepted release.
- `bounce_det`, out, 1: one-cycle pulse when a pending transition is aborted by bounce.

## Operation
- Two-flop synchroniser on `btn_n`; both flops reset to 1 (released). `sync` is the second flop.
- A stability counter is sized by `$clog2(DEBOUNCE_CYCLES)` and saturates at `DEBOUNCE_CYCLES-1`.
- FSM states:
  - IDLE:
    - `sync`=0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT:
    - `sync`=1 → IDLE, `bounce_det` pulses.
    - Otherwise the counter increments.
    - `sync`=0 with counter == `DEBOUNCE_CYCLES-1` → HELD, `press_pulse` pulses, `btn_level`←1.
  - HELD:
    - `sync`=1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT:
    - `sync`=0 → HELD, `bounce_det` pulses, no `press_pulse`.
    - `sync`=1 with counter == `DEBOUNCE_CYCLES-1` → IDLE, `release_pulse` pulses, `btn_level`←0.
- All outputs are registered. `press_pulse`, `release_pulse` and `bounce_det` are mutually exclusive in any cycle.
- `btn_level` stays 1 throughout HELD and RELEASE_WAIT, and 0 throughout IDLE and PRESS_WAIT.
- Every accepted press produces exactly one `release_pulse` before the next non-repeat `press_pulse`.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0, synchroniser flops 1. `btn_level`, `press_pulse`, `release_pulse` and `bounce_det` are all 0.
- Press latency: `btn_n` is first sampled low at edge k and held low. PRESS_WAIT is entered at edge k+2. `press_pulse` is high for exactly the cycle after edge k+2+`DEBOUNCE_CYCLES`, and `btn_level` rises at the same edge.
- Release latency is symmetric: `DEBOUNCE_CYCLES`+2 edges from the first sampled-high edge.
- Any single-cycle opposite sample during a WAIT state aborts it. The next stable run restarts counting from 0; counts are never accumulated across bounces.
- Reset asserted mid-WAIT or mid-HELD: immediate return to reset values. No pulse is emitted on reset entry or exit.
- A button held low through reset release is treated as a new press: accepted `DEBOUNCE_CYCLES`+2 edges after release.

## Configuration
- Macro: `BUTTON_DEBOUNCER_AUTOREPEAT_EN`.
- Defined:
  - In HELD, a repeat counter (cleared on every entry to HELD) counts cycles.
  - An additional `press_pulse` is emitted after `REPEAT_DELAY` cycles in HELD, then every `REPEAT_PERIOD` cycles while HELD persists.
  - The repeat counter holds its value in RELEASE_WAIT. It is cleared if the FSM returns to HELD from RELEASE_WAIT.
- Undefined: no repeat logic is synthesised; `REPEAT_*` are ignored; exactly one `press_pulse` per accepted press.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5 throughout.
- Reset, then `btn_n`=1 for 20 cycles → all outputs 0, no pulses.
- Clean press: `btn_n` goes 0 at edge 10 and is held for 30 cycles → single `press_pulse` in the cycle after edge 16, `btn_level`=1 from edge 16. Release at edge 40 → `release_pulse` after edge 46, `btn_level`=0.
- Bounce: `btn_n` toggles 0/1 every 2 cycles for 12 cycles, then holds 0 → `bounce_det` pulses on each abort. Exactly one `press_pulse`, 6 edges after the last falling sample.
- Reset asserted 2 cycles into PRESS_WAIT → outputs 0 immediately, no `press_pulse`. With the button still low, a press is accepted 6 edges after reset release.
- Release glitch: in HELD, `btn_n`=1 for 2 cycles then back to 0 → `bounce_det`=1, `btn_level` stays 1, no `release_pulse` and no second `press_pulse`.
- With `BUTTON_DEBOUNCER_AUTOREPEAT_EN`, hold the button for 40 cycles after acceptance → `press_pulse` at acceptance, then at +10, +15, +20, +25, +30, +35 cycles. Without the macro → exactly one `press_pulse`.

Source files
------------

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces an active-low push-button.
// Optional auto-repeat of press_pulse: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic bounce_det
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          sync_1;
    logic          sync;
    logic          level_d;
    logic          press_d;
    logic          release_d;
    logic          bounce_d;

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RDEL = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_d;
    logic [RW-1:0] rep_target;
    logic          rep_phase;
    logic          rep_phase_d;

    // first repeat waits the long delay, later ones the period
    assign rep_target = rep_phase ? RPER : RDEL;

    // repeat counter and delay/period phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_d;
            rep_phase <= rep_phase_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    // two-flop synchroniser, idles in the released state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync   <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync   <= sync_1;
        end
    end

    // state, stability counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            bounce_det    <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            bounce_det    <= bounce_d;
        end
    end

    // next state: a single opposite sample in a wait state aborts it
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        press_d   = 1'b0;
        release_d = 1'b0;
        bounce_d  = 1'b0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        rep_cnt_d   = rep_cnt;
        rep_phase_d = rep_phase;
`endif
        unique case (state)
            IDLE: begin
                if (!sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync) begin
                    state_d  = IDLE;
                    bounce_d = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_d = HELD;
                    press_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            HELD: begin
                if (sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                else if (rep_cnt == rep_target) begin
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!sync) begin
                    state_d  = HELD;
                    bounce_d = 1'b1;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                    rep_cnt_d   = '0;
                    rep_phase_d = 1'b0;
`endif
                end else if (cnt == CNT_MAX) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: segment table plus event scoreboard.
// Honours BUTTON_DEBOUNCER_AUTOREPEAT_EN for the long-hold sequence.
module tb_button_debouncer;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 5;
    localparam int NV = 23;

    typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_BOUNCE} ev_t;

    typedef struct {
        ev_t kind;
        int  cyc;
    } exp_t;

    typedef struct {
        logic btn;
        int   len;
        ev_t  ev;
        int   dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_n = 1'b1;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic bounce_det;

    exp_t sb[$];
    vec_t vecs [0:NV-1];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic exp_level = 1'b0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .bounce_det   (bounce_det)
    );

    always #5 clk = ~clk;

    // edge counter: after posedge number e, cyc == e
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act,
                         input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_t k, input int at);
        exp_t e;
        e.kind = k;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // hold btn for len edges; event expected at first edge + dly
    task automatic apply(input vec_t v);
        int k;
        k = cyc + 1;
        btn_n = v.btn;
        if (v.ev != EV_NONE) expect_ev(v.ev, k + v.dly);
        repeat (v.len) @(negedge clk);
    endtask

    // scoreboard monitor, sampled away from the active edge
    always @(negedge clk) begin : mon
        logic ep;
        logic er;
        logic eb;
        ep = 1'b0;
        er = 1'b0;
        eb = 1'b0;
        if (!rst) begin
            exp_level = 1'b0;
            check("rst_level", btn_level, 1'b0);
            check("rst_press", press_pulse, 1'b0);
            check("rst_release", release_pulse, 1'b0);
            check("rst_bounce", bounce_det, 1'b0);
        end else begin
            while (sb.size() != 0 && sb[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event @cycle %0d: kind %0d due %0d",
                         cyc, sb[0].kind, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                ep = (sb[0].kind == EV_PRESS);
                er = (sb[0].kind == EV_RELEASE);
                eb = (sb[0].kind == EV_BOUNCE);
                void'(sb.pop_front());
            end
            if (ep) exp_level = 1'b1;
            if (er) exp_level = 1'b0;
            check("press_pulse", press_pulse, ep);
            check("release_pulse", release_pulse, er);
            check("bounce_det", bounce_det, eb);
            check("btn_level", btn_level, exp_level);
        end
    end

    initial begin
        int k;
        vecs = '{
            '{1'b1, 20, EV_NONE,    0},
            '{1'b0, 12, EV_PRESS,   6},
            '{1'b1, 12, EV_RELEASE, 6},
            '{1'b0,  2, EV_NONE,    0},
            '{1'b1,  2, EV_BOUNCE,  2},
            '{1'b0,  2, EV_NONE,    0},
            '{1'b1,  2, EV_BOUNCE,  2},
            '{1'b0,  2, EV_NONE,    0},
            '{1'b1,  2, EV_BOUNCE,  2},
            '{1'b0, 12, EV_PRESS,   6},
            '{1'b1,  2, EV_NONE,    0},
            '{1'b0,  8, EV_BOUNCE,  2},
            '{1'b1, 12, EV_RELEASE, 6},
            '{1'b0,  1, EV_NONE,    0},
            '{1'b1, 10, EV_BOUNCE,  2},
            '{1'b0, 12, EV_PRESS,   6},
            '{1'b1,  1, EV_NONE,    0},
            '{1'b0,  8, EV_BOUNCE,  2},
            '{1'b1, 12, EV_RELEASE, 6},
            '{1'b0,  4, EV_NONE,    0},
            '{1'b1, 10, EV_BOUNCE,  2},
            '{1'b0,  5, EV_PRESS,   6},
            '{1'b1, 10, EV_RELEASE, 6}
        };

        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) apply(vecs[i]);

        // reset two cycles into PRESS_WAIT, button kept low
        btn_n = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_wait_level", btn_level, 1'b0);
        check("rst_wait_press", press_pulse, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        k = cyc + 1;
        expect_ev(EV_PRESS, k + 6);
        repeat (12) @(negedge clk);

        // reset while HELD drops the level at once
        #2 rst = 1'b0;
        #1;
        check("rst_held_level", btn_level, 1'b0);
        check("rst_held_press", press_pulse, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k = cyc + 1;
        expect_ev(EV_PRESS, k + 6);
        repeat (12) @(negedge clk);
        apply('{1'b1, 10, EV_RELEASE, 6});

        // long hold: repeats only with the auto-repeat build
        k = cyc + 1;
        btn_n = 1'b0;
        expect_ev(EV_PRESS, k + 6);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
        for (int i = 0; i < 6; i++) expect_ev(EV_PRESS, k + 6 + RD + RP * i);
`endif
        repeat (44) @(negedge clk);
        apply('{1'b1, 10, EV_RELEASE, 6});

        repeat (10) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
